// File: rtl/dmem_ws.sv
// rtl/dmem_ws.sv - wait-state byte/half/word data memory behind a req/ready handshake
// Optional feature macro DMEM_ALIGN_CHECK_EN: flag and suppress misaligned half/word accesses.
module dmem_ws #(
  parameter int DEPTH = 64,
  parameter int WAIT  = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_memwrite,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned_ld,
  input  logic [31:0] i_dataadr,
  input  logic [31:0] i_writedata,
  output logic [31:0] o_readdata,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_err
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        r_state;
  logic [2:0]    r_cnt;
  logic          r_we;
  logic          r_uns;
  logic [1:0]    r_size;
  logic [AW+1:0] r_adr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_readdata;
  logic          r_ready;
  logic          r_busy;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH];

  logic          w_byte;
  logic          w_half;
  logic          w_mis;
  logic [1:0]    w_off;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [4:0]    w_sh;
  logic [31:0]   w_mask;
  logic [31:0]   w_wshift;
  logic [31:0]   w_store;
  logic [7:0]    w_lb;
  logic [15:0]   w_lh;
  logic [31:0]   w_load;
  logic          w_perform;
  logic          w_unused;

  // Address bits above the RAM window are deliberately ignored (wrap-around).
  assign w_unused = ^i_dataadr[31:AW+2];

  assign w_byte = (r_size == 2'b00);
  assign w_half = (r_size == 2'b01);
  assign w_idx  = r_adr[AW+1:2];
  assign w_word = r_mem[w_idx];

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_mis = (w_half & r_adr[0]) | (!w_byte && !w_half && (r_adr[1:0] != 2'b00));
  assign w_off = r_adr[1:0];
`else
  assign w_mis = 1'b0;
  assign w_off = w_byte ? r_adr[1:0] : (w_half ? {r_adr[1], 1'b0} : 2'b00);
`endif

  // Big-endian lanes: offset 0 is the most significant byte, so shift by (3-off) bytes.
  always_comb begin
    w_sh     = 5'd0;
    w_mask   = 32'hFFFF_FFFF;
    w_wshift = r_wdata;
    if (w_byte) begin
      w_sh     = {~w_off, 3'b000};
      w_mask   = 32'h0000_00FF << w_sh;
      w_wshift = {24'd0, r_wdata[7:0]} << w_sh;
    end else if (w_half) begin
      w_sh     = {~w_off[1], 4'b0000};
      w_mask   = 32'h0000_FFFF << w_sh;
      w_wshift = {16'd0, r_wdata[15:0]} << w_sh;
    end
    w_store = (w_word & ~w_mask) | (w_wshift & w_mask);
    w_lb    = 8'(w_word >> w_sh);
    w_lh    = 16'(w_word >> w_sh);
    if (w_byte)
      w_load = r_uns ? {24'd0, w_lb} : {{24{w_lb[7]}}, w_lb};
    else if (w_half)
      w_load = r_uns ? {16'd0, w_lh} : {{16{w_lh[15]}}, w_lh};
    else
      w_load = w_word;
  end

  assign w_perform = (r_state == S_BUSY) && (r_cnt == 3'd0);

  always_ff @(posedge i_clk) begin
    if (w_perform && r_we && !w_mis)
      r_mem[w_idx] <= w_store;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_we       <= 1'b0;
      r_uns      <= 1'b0;
      r_size     <= 2'b00;
      r_adr      <= '0;
      r_wdata    <= 32'd0;
      r_readdata <= 32'd0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_we    <= i_memwrite;
            r_size  <= i_size;
            r_uns   <= i_unsigned_ld;
            r_adr   <= i_dataadr[AW+1:0];
            r_wdata <= i_writedata;
            r_cnt   <= 3'(WAIT);
            r_busy  <= 1'b1;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end else begin
            if (!r_we && !w_mis)
              r_readdata <= w_load;
            r_err   <= w_mis;
            r_ready <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_readdata = r_readdata;
  assign o_ready    = r_ready;
  assign o_busy     = r_busy;
  assign o_err      = r_err;

endmodule

// File: tb/tb_dmem_ws.sv
// tb/tb_dmem_ws.sv - self-checking bench for dmem_ws: byte-array reference model plus WAIT 0..7 sweep
// Expectations follow DMEM_ALIGN_CHECK_EN when it is defined for the build.
module tb_dmem_ws;
  localparam int MW = 4;
  localparam int NB = 256;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  logic        m_req, m_we, m_uns;
  logic [1:0]  m_size;
  logic [31:0] m_adr, m_wd;
  wire  [31:0] m_rd;
  wire         m_ready, m_busy, m_err;

  logic [7:0]  s_req;
  logic        s_we, s_uns;
  logic [1:0]  s_size;
  logic [31:0] s_adr, s_wd;
  wire  [31:0] s_rd [8];
  wire  [7:0]  s_ready, s_busy, s_err;

  dmem_ws #(.DEPTH(64), .WAIT(MW)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_req(m_req), .i_memwrite(m_we), .i_size(m_size),
    .i_unsigned_ld(m_uns), .i_dataadr(m_adr), .i_writedata(m_wd),
    .o_readdata(m_rd), .o_ready(m_ready), .o_busy(m_busy), .o_err(m_err)
  );

  for (genvar g = 0; g < 8; g++) begin : g_sweep
    dmem_ws #(.DEPTH(64), .WAIT(g)) u_sw (
      .i_clk(clk), .i_reset(rst), .i_req(s_req[g]), .i_memwrite(s_we), .i_size(s_size),
      .i_unsigned_ld(s_uns), .i_dataadr(s_adr), .i_writedata(s_wd),
      .o_readdata(s_rd[g]), .o_ready(s_ready[g]), .o_busy(s_busy[g]), .o_err(s_err[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference memory as a flat big-endian byte array: byte address a lives in mb[a mod 256].
  logic [7:0] mb [NB];

  function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] adr, input logic [31:0] wd,
                                output logic mis, output logic upd, output logic [31:0] rd);
    int n;
    int base;
    logic [31:0] v;
    n    = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
    base = int'(adr % NB);
    mis  = ALIGN && ((base % n) != 0);
    if (!ALIGN) base = base - (base % n);
    upd = 1'b0;
    rd  = 32'd0;
    if (mis) return;
    if (we) begin
      for (int i = 0; i < n; i++) mb[base + i] = 8'(wd >> (8 * (n - 1 - i)));
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = (v << 8) | {24'd0, mb[base + i]};
      if (n < 4 && !uns && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
      upd = 1'b1;
      rd  = v;
    end
  endfunction

  int          cur_a = -1000;
  logic        cur_mis = 1'b0, cur_upd = 1'b0;
  logic [31:0] cur_rd = 32'd0;
  logic [31:0] exp_rd = 32'd0;
  logic        cmp_en = 1'b0;
  logic        exp_ready, exp_busy, exp_err;

  always @(negedge clk) begin
    if (cmp_en) begin
      exp_ready = (cyc == cur_a + MW + 1);
      exp_busy  = (cyc >= cur_a) && (cyc <= cur_a + MW + 1);
      exp_err   = exp_ready && cur_mis;
      if (exp_ready && cur_upd) exp_rd = cur_rd;
      chk("cmp_ready", {31'd0, m_ready}, {31'd0, exp_ready});
      chk("cmp_busy",  {31'd0, m_busy},  {31'd0, exp_busy});
      chk("cmp_err",   {31'd0, m_err},   {31'd0, exp_err});
      chk("cmp_rd",    m_rd, exp_rd);
    end
  end

  task automatic m_access(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] adr, input logic [31:0] wd);
    logic mis, upd, got;
    logic [31:0] rd;
    model(we, sz, uns, adr, wd, mis, upd, rd);
    m_we = we; m_size = sz; m_uns = uns; m_adr = adr; m_wd = wd; m_req = 1'b1;
    cur_a = cyc + 1; cur_mis = mis; cur_upd = upd; cur_rd = rd;
    got = 1'b0;
    for (int t = 0; t < MW + 4 && !got; t++) begin
      @(negedge clk);
      m_we = 1'($urandom_range(0, 1)); m_size = 2'($urandom_range(0, 3));
      m_uns = 1'($urandom_range(0, 1)); m_adr = $urandom; m_wd = $urandom;
      if (m_ready) begin
        got   = 1'b1;
        m_req = 1'b0;
      end
    end
    chk("main_ready_seen", {31'd0, got}, 32'd1);
    m_req = 1'b0;
    repeat (1 + $urandom_range(0, 2)) @(negedge clk);
  endtask

  // All eight WAIT instances accept on the same edge; each must finish WAIT+1 edges later.
  task automatic sweep(input string name, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] adr, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eerr);
    logic [7:0] done;
    int a;
    s_we = we; s_size = sz; s_uns = uns; s_adr = adr; s_wd = wd; s_req = 8'hFF;
    a = cyc + 1;
    done = 8'h00;
    for (int t = 0; t < 14 && done != 8'hFF; t++) begin
      @(negedge clk);
      s_we = 1'($urandom_range(0, 1)); s_size = 2'($urandom_range(0, 3));
      s_uns = 1'($urandom_range(0, 1)); s_adr = $urandom; s_wd = $urandom;
      for (int g = 0; g < 8; g++) begin
        if (!done[g] && s_ready[g]) begin
          done[g]  = 1'b1;
          s_req[g] = 1'b0;
          chk($sformatf("%s_lat_w%0d", name, g), 32'(cyc - a), 32'(g + 1));
          chk($sformatf("%s_rd_w%0d", name, g), s_rd[g], erd);
          chk($sformatf("%s_err_w%0d", name, g), {31'd0, s_err[g]}, {31'd0, eerr});
          chk($sformatf("%s_busy_w%0d", name, g), {31'd0, s_busy[g]}, 32'd1);
        end
      end
    end
    chk($sformatf("%s_all_done", name), {24'd0, done}, 32'h0000_00FF);
    s_req = 8'h00;
    @(negedge clk);
  endtask

  initial begin
    logic mis, upd;
    logic [31:0] rd;
    m_req = 1'b0; m_we = 1'b0; m_uns = 1'b0; m_size = 2'd0; m_adr = 32'd0; m_wd = 32'd0;
    s_req = 8'h00; s_we = 1'b0; s_uns = 1'b0; s_size = 2'd0; s_adr = 32'd0; s_wd = 32'd0;

    @(negedge clk);
    chk("rst_rd", m_rd, 32'd0);
    chk("rst_flags", {29'd0, m_ready, m_busy, m_err}, 32'd0);
    chk("rst_sweep_flags", {8'd0, s_ready, s_busy, s_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    model(1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, mis, upd, rd);
    model(1'b0, 2'd0, 1'b0, 32'h12, 32'd0, mis, upd, rd);
    chk("pin_lb_pos", rd, 32'h0000_0056);
    model(1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF80, mis, upd, rd);
    model(1'b1, 2'd0, 1'b0, 32'h10, 32'h0000009A, mis, upd, rd);
    model(1'b0, 2'd1, 1'b0, 32'h10, 32'd0, mis, upd, rd);
    chk("pin_lh_neg", rd, 32'hFFFF_9A80);
    model(1'b0, 2'd0, 1'b1, 32'h11, 32'd0, mis, upd, rd);
    chk("pin_lbu", rd, 32'h0000_0080);
    model(1'b0, 2'd0, 1'b0, 32'h11, 32'd0, mis, upd, rd);
    chk("pin_lb_neg", rd, 32'hFFFF_FF80);
    model(1'b0, 2'd2, 1'b0, 32'h110, 32'd0, mis, upd, rd);
    chk("pin_wrap", rd, 32'h9A80_5678);
    model(1'b1, 2'd2, 1'b0, 32'h13, 32'hAABBCCDD, mis, upd, rd);
    chk("pin_mis", {31'd0, mis}, {31'd0, ALIGN});
    model(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, mis, upd, rd);
    chk("pin_mis_word", rd, ALIGN ? 32'h9A80_5678 : 32'hAABB_CCDD);

    sweep("sw10",   1'b1, 2'd2, 1'b0, 32'h10,  32'h12345678, 32'h0000_0000, 1'b0);
    sweep("lw10",   1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h1234_5678, 1'b0);
    sweep("sb12",   1'b1, 2'd0, 1'b0, 32'h12,  32'hFFFFFFAB, 32'h1234_5678, 1'b0);
    sweep("lw10b",  1'b0, 2'd2, 1'b1, 32'h10,  32'h0,        32'h1234_AB78, 1'b0);
    sweep("lb13",   1'b0, 2'd0, 1'b0, 32'h13,  32'h0,        32'h0000_0078, 1'b0);
    sweep("lb12",   1'b0, 2'd0, 1'b0, 32'h12,  32'h0,        32'hFFFF_FFAB, 1'b0);
    sweep("lbu12",  1'b0, 2'd0, 1'b1, 32'h12,  32'h0,        32'h0000_00AB, 1'b0);
    sweep("sw20",   1'b1, 2'd2, 1'b0, 32'h20,  32'h11223344, 32'h0000_00AB, 1'b0);
    sweep("sh20",   1'b1, 2'd1, 1'b0, 32'h20,  32'h55558001, 32'h0000_00AB, 1'b0);
    sweep("lh20",   1'b0, 2'd1, 1'b0, 32'h20,  32'h0,        32'hFFFF_8001, 1'b0);
    sweep("lhu20",  1'b0, 2'd1, 1'b1, 32'h20,  32'h0,        32'h0000_8001, 1'b0);
    sweep("lw20",   1'b0, 2'd2, 1'b0, 32'h20,  32'h0,        32'h8001_3344, 1'b0);
    sweep("sw100",  1'b1, 2'd2, 1'b0, 32'h100, 32'hCAFEF00D, 32'h8001_3344, 1'b0);
    sweep("lw000",  1'b0, 2'd3, 1'b0, 32'h000, 32'h0,        32'hCAFE_F00D, 1'b0);
    sweep("sw40",   1'b1, 2'd2, 1'b0, 32'h40,  32'h01020304, 32'hCAFE_F00D, 1'b0);
    sweep("sw41",   1'b1, 2'd2, 1'b0, 32'h41,  32'hDEADBEEF, 32'hCAFE_F00D, ALIGN);
    sweep("lw40",   1'b0, 2'd2, 1'b0, 32'h40,  32'h0,
          ALIGN ? 32'h0102_0304 : 32'hDEAD_BEEF, 1'b0);

    cmp_en = 1'b1;
    for (int w = 0; w < 64; w++) m_access(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom);
    for (int k = 0; k < 250; k++)
      m_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               $urandom, $urandom);

    m_access(1'b1, 2'd2, 1'b0, 32'h30, 32'h11111111);
    cmp_en = 1'b0;
    m_we = 1'b1; m_size = 2'd2; m_uns = 1'b0; m_adr = 32'h30; m_wd = 32'h55; m_req = 1'b1;
    @(negedge clk);
    m_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_rd", m_rd, 32'd0);
    chk("rst_mid_flags", {29'd0, m_ready, m_busy, m_err}, 32'd0);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("rst_hold_rd", m_rd, 32'd0);
      chk("rst_hold_flags", {29'd0, m_ready, m_busy, m_err}, 32'd0);
    end
    rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk("rst_after_flags", {29'd0, m_ready, m_busy, m_err}, 32'd0);
    end
    exp_rd = 32'd0;
    cur_a  = -1000;
    cmp_en = 1'b1;
    m_access(1'b0, 2'd2, 1'b0, 32'h30, 32'd0);
    chk("rst_store_dropped", m_rd, 32'h1111_1111);
    cmp_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dmem_ws.md
# dmem_ws

Parametrised wait-state data memory for the MIPS processor top level, replacing the single-cycle data memory with store-byte-only support. It serves byte, halfword and word loads and stores, with sign or zero extension on loads. Each access uses a req/ready handshake with a configurable number of wait cycles. It sits between the processor's data port and local word-addressed RAM, so stalling controllers can be exercised against slow memory.

## Interface
- DEPTH, 64: number of 32-bit words; power of two, 4..4096
- WAIT, 1: wait cycles per access, 0..7

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req  in  1  access request, held by requester until ready
- memwrite  in  1  1 = store, 0 = load; sampled with req
- size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- unsigned_ld  in  1  1 = zero-extend sub-word loads, 0 = sign-extend
- dataadr  in  32  byte address
- writedata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- readdata  out  32  load result, held until next load completes
- ready  out  1  one-cycle completion pulse
- busy  out  1  high in BUSY and DONE
- err  out  1  misalignment flag, valid only while ready

## Operation
- Word index is dataadr[log2(DEPTH)+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Byte order is big-endian:
  - byte offset 0 is bits [31:24], offset 3 is bits [7:0];
  - half offset 0 (dataadr[1]=0) is bits [31:16].
- Stores write only the addressed lanes. Other bytes of the word are untouched.
- Loads extract the addressed lane and right-justify it. They extend per unsigned_ld; word loads ignore unsigned_ld.
- FSM states:
  - IDLE: if req=1, capture memwrite, size, unsigned_ld, dataadr and writedata. Load cnt=WAIT and go to BUSY.
  - BUSY: if cnt≠0, decrement cnt. If cnt=0, perform the access at this edge (RAM write, or readdata update) and go to DONE.
  - DONE: ready=1 for exactly this cycle; go to IDLE.
- req is ignored in BUSY and DONE. A new access is accepted only in IDLE.
- Captured values are used for the whole access; input changes after acceptance have no effect.
- Stores leave readdata unchanged.
- Reset values: state IDLE, cnt 0, ready 0, busy 0, err 0, readdata 0. RAM contents are not cleared.
- Reset asserted mid-access aborts it: a pending store is dropped, no ready pulse, and the FSM returns to IDLE.

## Timing
- Accept edge E0 is the rising edge where state=IDLE and req=1.
- The access is performed at edge E0+WAIT+1.
- ready is high during the cycle after E0+WAIT+1.
- Minimum spacing between accept edges is WAIT+3 cycles.
- busy rises after E0 and falls after the DONE cycle.
- readdata changes only at the perform edge of a load, and is valid in the ready cycle.
- With WAIT=0, E0 is followed by BUSY for one cycle, then DONE.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - a half access with dataadr[0]=1 is misaligned;
  - a word access with dataadr[1:0]≠00 is misaligned;
  - a misaligned access completes with normal timing and err=1 in the ready cycle;
  - a misaligned store writes nothing, and a misaligned load leaves readdata unchanged.
- DMEM_ALIGN_CHECK_EN undefined:
  - err is tied to 0;
  - misaligned low bits are forced to zero (half uses dataadr[1] only; word ignores [1:0]).

## Test plan
- Word round trip (WAIT=1): sw 0x12345678 at 0x10, then lw 0x10 → ready 2 cycles after each accept edge; readdata=0x12345678.
- Byte lanes: after word 0x12345678 at 0x10, sb 0xAB at 0x12, then lw 0x10 → 0x1234AB78. lb 0x13 → 0x00000078. lb 0x12 → 0xFFFFFFAB; lbu 0x12 → 0x000000AB.
- Halfword: sh 0x8001 at 0x20, then lh 0x20 → 0xFFFF8001; lhu 0x20 → 0x00008001; lw 0x20 → 0x8001xxxx with the low half unchanged.
- Wrap and wait sweep: DEPTH=64, sw 0xCAFEF00D at 0x100, then lw 0x000 → 0xCAFEF00D. Repeat for WAIT=0..7 and check ready at exactly accept+WAIT+1+1 cycles.
- Misalignment with DMEM_ALIGN_CHECK_EN: sw 0xDEADBEEF at 0x41 → err=1 with ready and word 0x40 unchanged. Without the macro → word 0x40 reads 0xDEADBEEF and err=0.
- Reset mid-access (WAIT=4): accept sw 0x55 at 0x30, assert reset 2 cycles later → ready never pulses; word 0x30 keeps its old value; all outputs are 0 during reset; the next access is accepted normally.
